// File: rtl/ssd_scan_if.sv
// ============================================================================
// ssd_scan_if : load/value bus and scan outputs of the seven-segment scanner
// Revision 1.0
// ============================================================================
`default_nettype none

interface ssd_scan_if;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic [3:0]  nibble_out;
    logic [3:0]  anode_out;
    logic        dp_out;
    logic        frame_done;
    logic        pending;

    modport master (
        output value_in, load, blank_in, dp_in,
        input  nibble_out, anode_out, dp_out, frame_done, pending
    );

    modport slave (
        input  value_in, load, blank_in, dp_in,
        output nibble_out, anode_out, dp_out, frame_done, pending
    );
endinterface

`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
// ssd_scan_ctrl : four-digit multiplexed seven-segment scan controller with
// frame-synchronous value update. Optional macro: SSD_ZERO_BLANK_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module ssd_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ssd_scan_if.slave  bus
);

    localparam int            CW           = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] C_CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [15:0]   stg_val_q, stg_val_d;
    logic [3:0]    stg_blank_q, stg_blank_d;
    logic [3:0]    stg_dp_q, stg_dp_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_blank_q, disp_blank_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          dp_q, dp_d;
    logic          pending_q, pending_d;

    logic          w_enter_guard;
    logic          w_frame_copy;
    logic [3:0]    w_next_blank;
    logic [3:0]    w_cur_blank;
    logic          w_lit;

`ifdef SSD_ZERO_BLANK_EN
    // Leading-zero suppression: digit k dark when it and all higher nibbles are 0.
    function automatic logic [3:0] zero_blank(input logic [15:0] v);
        logic z3, z2, z1;
        z3 = (v[15:12] == 4'h0);
        z2 = z3 && (v[11:8] == 4'h0);
        z1 = z2 && (v[7:4] == 4'h0);
        return {z3, z2, z1, 1'b0};
    endfunction
`endif

    always_comb begin
        state_d       = state_q;
        d_d           = d_q;
        cnt_d         = cnt_q;
        w_enter_guard = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d       = S_GUARD;
                d_d           = 2'd0;
                cnt_d         = '0;
                w_enter_guard = 1'b1;
            end
            S_GUARD: begin
                cnt_d = cnt_q + C_CNT_ONE;
                if (cnt_q == C_GUARD_LAST) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (cnt_q == C_CNT_LAST) begin
                    state_d       = S_GUARD;
                    cnt_d         = '0;
                    d_d           = d_q + 2'd1;
                    w_enter_guard = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                d_d     = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Staging only reaches the display at the digit-0 boundary so a frame never mixes values.
    always_comb begin
        w_frame_copy = w_enter_guard && (d_d == 2'd0);

        stg_val_d   = stg_val_q;
        stg_blank_d = stg_blank_q;
        stg_dp_d    = stg_dp_q;
        if (bus.load) begin
            stg_val_d   = bus.value_in;
            stg_blank_d = bus.blank_in;
            stg_dp_d    = bus.dp_in;
        end
        pending_d = bus.load | (pending_q & ~w_frame_copy);

        disp_val_d   = disp_val_q;
        disp_blank_d = disp_blank_q;
        disp_dp_d    = disp_dp_q;
        if (w_frame_copy) begin
            disp_val_d   = stg_val_q;
            disp_blank_d = stg_blank_q;
            disp_dp_d    = stg_dp_q;
        end

`ifdef SSD_ZERO_BLANK_EN
        w_next_blank = disp_blank_d | zero_blank(disp_val_d);
`else
        w_next_blank = disp_blank_d;
`endif

        nibble_d = nibble_q;
        dp_d     = dp_q;
        if (w_enter_guard) begin
            nibble_d = disp_val_d[{d_d, 2'b00} +: 4];
            dp_d     = ~disp_dp_d[d_d] | w_next_blank[d_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            d_q          <= 2'd0;
            cnt_q        <= '0;
            stg_val_q    <= 16'h0000;
            stg_blank_q  <= 4'hF;
            stg_dp_q     <= 4'h0;
            disp_val_q   <= 16'h0000;
            disp_blank_q <= 4'hF;
            disp_dp_q    <= 4'h0;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b1;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            cnt_q        <= cnt_d;
            stg_val_q    <= stg_val_d;
            stg_blank_q  <= stg_blank_d;
            stg_dp_q     <= stg_dp_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            disp_dp_q    <= disp_dp_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            pending_q    <= pending_d;
        end
    end

`ifdef SSD_ZERO_BLANK_EN
    assign w_cur_blank = disp_blank_q | zero_blank(disp_val_q);
`else
    assign w_cur_blank = disp_blank_q;
`endif

    assign w_lit          = (state_q == S_ON) && !w_cur_blank[d_q];
    assign bus.anode_out  = w_lit ? ~(4'b0001 << d_q) : 4'b1111;
    // Decimal point is held dark during the guard so it never lights on a dark digit.
    assign bus.dp_out     = dp_q | (state_q != S_ON);
    assign bus.nibble_out = nibble_q;
    assign bus.frame_done = (state_q == S_ON) && (d_q == 2'd3) && (cnt_q == C_CNT_LAST);
    assign bus.pending    = pending_q;

endmodule

`default_nettype wire

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot, legal range 4..2^20, including guard.
REQ-002 Parameter GUARD, default 16: blanking cycles at the start of each slot, legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 value_in  input  16  four hex nibbles; digit k is value_in[4k+3:4k], digit 0 rightmost.
REQ-006 load  input  1  single-cycle strobe requesting capture of value_in, blank_in and dp_in.
REQ-007 blank_in  input  4  per-digit force-blank, 1 = digit dark.
REQ-008 dp_in  input  4  per-digit decimal point, 1 = lit.
REQ-009 nibble_out  output  4  nibble of the active digit, fed to the seven-segment decoder binary input.
REQ-010 anode_out  output  4  active-low digit enables; at most one bit low at any time.
REQ-011 dp_out  output  1  active-low decimal point for the active digit.
REQ-012 frame_done  output  1  one-cycle pulse on the final cycle of digit 3's slot.
REQ-013 pending  output  1  high while a captured load has not yet been applied to the display.

Function
REQ-014 States: IDLE, GUARD, ON; digit index d in 0..3; slot counter cnt in 0..REFRESH_DIV-1.
REQ-015 IDLE lasts exactly one cycle after reset release, then moves to GUARD with d=0 and cnt=0.
REQ-016 GUARD: anode_out=4'b1111 for cnt 0..GUARD-1, then ON at cnt=GUARD.
REQ-017 ON: anode_out bit d low unless digit d is blanked; at cnt=REFRESH_DIV-1, go to GUARD, reset cnt to 0, and set d=(d+1) mod 4, wrapping 3->0.
REQ-018 nibble_out and dp_out come from the display register for digit d, are registered, and change only on the cycle GUARD is entered.
REQ-019 A load captures value_in, blank_in and dp_in into a staging register the next cycle and sets pending.
REQ-020 Staging is copied to the display register when GUARD is entered for d=0, which clears pending; this prevents a frame from mixing two values.
REQ-021 A second load while pending is high overwrites staging; only the last value captured before the frame boundary is shown.
REQ-022 If load occurs on the same cycle as the frame-boundary copy, the old staging is applied, the new value is captured, and pending stays high.
REQ-023 A blanked digit holds anode_out=4'b1111 for its whole slot, and dp_out is 1 for that slot.
REQ-024 frame_done asserts when d=3 and cnt=REFRESH_DIV-1, regardless of blanking.

Reset
REQ-025 While rst_n is low: state=IDLE, d=0, cnt=0, anode_out=4'b1111, nibble_out=0, dp_out=1, frame_done=0, pending=0, staging and display registers zero, blank bits all 1.
REQ-026 Reset asserted mid-slot forces every output to its reset value immediately and asynchronously; after release, scanning restarts per REQ-015.

Configuration
REQ-027 Macro SSD_ZERO_BLANK_EN defined: digit k (k=3,2,1) is additionally blanked when its nibble and every higher nibble in the display register are 0; digit 0 is never auto-blanked.
REQ-028 Macro SSD_ZERO_BLANK_EN undefined: only blank_in blanks digits, and no comparison logic is synthesised.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-029 Reset release, then load with value_in=16'h1234, blank_in=0, dp_in=0 -> frame 2 shows nibble_out 4,3,2,1 with anode_out 1110,1101,1011,0111 for 6 cycles each, 1111 for 2 cycles between slots.
REQ-030 Loads of 16'hAAAA then 16'h5555, 3 cycles apart mid-frame -> the next frame shows only 5, and pending falls on the first GUARD cycle of d=0.
REQ-031 dp_in=4'b0100, blank_in=4'b1000 -> dp_out=0 only in digit 2's ON cycles; digit 3's slot keeps anode_out=1111.
REQ-032 rst_n pulled low at cnt=5 of digit 2 -> same-cycle anode_out=1111 and nibble_out=0; after release, one IDLE cycle, then digit 0 GUARD.
REQ-033 With SSD_ZERO_BLANK_EN and value_in=16'h0070 -> digits 3 and 2 dark, digits 1 and 0 lit; value_in=16'h0000 -> only digit 0 lit, showing 0.
REQ-034 Over 3 frames, frame_done pulses every 32 cycles, and anode_out never has two bits low in the same cycle.
